uart_rx_fifo: RTL and testbench

Receive-side byte FIFO between the `uart_rx` receiver and the CPU peripheral read mux. It drains received bytes from the receiver as soon as they are valid. It holds them in a small circular buffer and presents the oldest byte and status flags to the `PERI_UART` / `PERI_UART_STATUS` read paths. It also raises flow control before the buffer fills, so bursts from the host survive CPU latency (SPI instruction fetch).

---
 rtl/uart_rx_fifo.sv | 116 +++++++++++
 tb/tb_uart_rx_fifo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between uart_rx and the CPU read mux.
// Drains the receiver byte by byte into a circular buffer. Presents the
// oldest byte and status flags, and raises rts before the buffer fills.
//
// Optional feature macro: UART_RX_FIFO_OVERRUN_EN
//   defined   -> drop mode: bytes arriving while full are acked, discarded
//                and flagged in a sticky overrun bit.
//   undefined -> backpressure mode: no ack while full, overrun tied to 0.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid     receiver holds an unread byte
//   in_data      receiver byte
//   in_read      registered one-cycle ack pulse to the receiver
//   pop          CPU read strobe (rd_data is sampled in the same cycle)
//   rd_data      head byte, 0 when empty
//   not_empty    level != 0
//   full         level == DEPTH
//   level        occupancy count
//   rts          level >= RTS_LEVEL, asks the sender to pause
//   overrun      sticky overrun flag
//   clr_overrun  clears overrun (set wins on a coincident edge)
// The status byte built above this block is {5'b0, overrun, not_empty, tx_busy}.

module uart_rx_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RTS_LEVEL = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_read,
    input  logic                     pop,
    output logic [7:0]               rd_data,
    output logic                     not_empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rts,
    output logic                     overrun,
    input  logic                     clr_overrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    logic capture_c;
    logic pop_c;
    logic drop_c;

    // Flags decoded from the registered level only.
    assign not_empty = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign rts       = (level >= LW'(RTS_LEVEL));
    assign rd_data   = not_empty ? mem[rp] : 8'h00;

    // The cycle with in_read high is a gap so the receiver can drop in_valid.
    assign capture_c = in_valid && !in_read && !full;
    assign pop_c     = pop && not_empty;

`ifdef UART_RX_FIFO_OVERRUN_EN
    assign drop_c = in_valid && !in_read && full;

    // Sticky overrun; a set on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop_c) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_clr_overrun;

    assign drop_c             = 1'b0;
    assign overrun            = 1'b0;
    assign unused_clr_overrun = clr_overrun;
`endif

    // Storage is not reset; stale entries are hidden by level.
    always_ff @(posedge clk) begin
        if (capture_c) begin
            mem[wp] <= in_data;
        end
    end

    // Pointers, occupancy and receiver ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            level   <= '0;
            in_read <= 1'b0;
        end else begin
            in_read <= capture_c || drop_c;
            if (capture_c) begin
                wp <= wp + AW'(1);
            end
            if (pop_c) begin
                rp <= rp + AW'(1);
            end
            case ({capture_c, pop_c})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_read;
    logic       pop;
    logic [7:0] rd_data;
    logic       not_empty;
    logic       full;
    logic [2:0] level;
    logic       rts;
    logic       overrun;
    logic       clr_overrun;

    int         checks;
    int         errors;
    int         pulses;
    logic       prev_in_read;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.DEPTH(4), .RTS_LEVEL(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_read     (in_read),
        .pop         (pop),
        .rd_data     (rd_data),
        .not_empty   (not_empty),
        .full        (full),
        .level       (level),
        .rts         (rts),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare on every CPU read, ack pulse accounting.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_read) begin
                pulses++;
                check("in_read_gap", 32'(prev_in_read), 32'd0);
            end
            prev_in_read = in_read;
            if (pop && not_empty) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop_data", 32'(rd_data), 32'hFFFF);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
            end else if (pop) begin
                check("empty_pop_rd_data", 32'(rd_data), 32'd0);
            end
        end else begin
            prev_in_read = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit got;
        got = 1'b0;
        exp_q.push_back(b);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (in_read) begin
                got = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        check("send_ack", 32'(got), 32'd1);
    endtask

    task automatic pop_byte();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"},     32'(level),     32'd0);
        check({tag, "_in_read"},   32'(in_read),   32'd0);
        check({tag, "_not_empty"}, 32'(not_empty), 32'd0);
        check({tag, "_full"},      32'(full),      32'd0);
        check({tag, "_rts"},       32'(rts),       32'd0);
        check({tag, "_rd_data"},   32'(rd_data),   32'd0);
        check({tag, "_overrun"},   32'(overrun),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        checks       = 0;
        errors       = 0;
        pulses       = 0;
        prev_in_read = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        pop          = 1'b0;
        clr_overrun  = 1'b0;
        repeat (3) tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        // Single byte held valid for two cycles: exactly one ack.
        snap = pulses;
        exp_q.push_back(8'hA5);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        check("single_ack", 32'(in_read), 32'd1);
        check("single_level_n1", 32'(level), 32'd1);
        tick();
        in_valid = 1'b0;
        check("single_gap", 32'(in_read), 32'd0);
        tick();
        check("single_pulses", 32'(pulses - snap), 32'd1);
        check("single_level", 32'(level), 32'd1);
        check("single_rd_data", 32'(rd_data), 32'hA5);
        check("single_not_empty", 32'(not_empty), 32'd1);
        pop_byte();
        check("single_level_after_pop", 32'(level), 32'd0);
        check("single_rd_after_pop", 32'(rd_data), 32'd0);

        // Fill and order with rts threshold.
        send(8'h01);
        send(8'h02);
        check("fill_rts_at_2", 32'(rts), 32'd0);
        send(8'h03);
        check("fill_rts_at_3", 32'(rts), 32'd1);
        send(8'h04);
        tick();
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd4);
        check("fill_rts_at_4", 32'(rts), 32'd1);
`ifndef UART_RX_FIFO_OVERRUN_EN
        // Backpressure: no ack while full, capture one edge after a pop.
        snap     = pulses;
        in_valid = 1'b1;
        in_data  = 8'h05;
        repeat (4) tick();
        check("bp_no_ack", 32'(pulses - snap), 32'd0);
        check("bp_level", 32'(level), 32'd4);
        exp_q.push_back(8'h05);
        pop_byte();
        check("bp_no_capture_on_pop", 32'(in_read), 32'd0);
        check("bp_level_after_pop", 32'(level), 32'd3);
        tick();
        in_valid = 1'b0;
        check("bp_capture_next", 32'(in_read), 32'd1);
        check("bp_level_refill", 32'(level), 32'd4);
        check("bp_overrun_tied", 32'(overrun), 32'd0);
        repeat (4) pop_byte();
`else
        repeat (4) pop_byte();
`endif
        check("fill_drained", 32'(level), 32'd0);

        // Simultaneous capture and pop at level 2.
        send(8'h10);
        send(8'h11);
        tick();
        exp_q.push_back(8'h77);
        in_valid = 1'b1;
        in_data  = 8'h77;
        pop      = 1'b1;
        tick();
        pop      = 1'b0;
        in_valid = 1'b0;
        check("simul_ack", 32'(in_read), 32'd1);
        check("simul_level", 32'(level), 32'd2);
        check("simul_new_head", 32'(rd_data), 32'h11);
        tick();
        pop_byte();
        pop_byte();
        check("simul_drained", 32'(level), 32'd0);

        // Pop while empty must not move anything.
        pop_byte();
        check("empty_pop_level", 32'(level), 32'd0);
        check("empty_pop_not_empty", 32'(not_empty), 32'd0);
        check("empty_pop_full", 32'(full), 32'd0);
        send(8'h5A);
        tick();
        check("empty_pop_then_push", 32'(rd_data), 32'h5A);
        pop_byte();

`ifdef UART_RX_FIFO_OVERRUN_EN
        // Drop mode: ack, discard, sticky flag, set beats clear.
        send(8'hC1);
        send(8'hC2);
        send(8'hC3);
        send(8'hC4);
        tick();
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        in_valid = 1'b0;
        check("ovr_ack", 32'(in_read), 32'd1);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_level", 32'(level), 32'd4);
        tick();
        check("ovr_sticky", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        in_valid    = 1'b1;
        in_data     = 8'hEE;
        clr_overrun = 1'b1;
        tick();
        in_valid    = 1'b0;
        clr_overrun = 1'b0;
        check("ovr_set_wins", 32'(overrun), 32'd1);
        tick();
        repeat (4) pop_byte();
        check("ovr_drained", 32'(level), 32'd0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
`endif

        // Reset at level 3 with an ack pulse in flight.
        send(8'h21);
        send(8'h22);
        tick();
        exp_q.push_back(8'h23);
        in_valid = 1'b1;
        in_data  = 8'h23;
        tick();
        check("rst_pre_level", 32'(level), 32'd3);
        check("rst_pre_in_read", 32'(in_read), 32'd1);
        rst_n = 1'b0;
        tick();
        check_reset_state("midrst");
        exp_q.delete();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        send(8'h3C);
        tick();
        check("post_rst_head", 32'(rd_data), 32'h3C);
        pop_byte();

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
